fetch_buffer: RTL

//   Instruction prefetch stage between program memory and the stack CPU core.
//   - Streams consecutive 16-bit instruction words ahead of the CPU into a small FIFO.
//   - Serves the CPU's word-address requests: two bytes per word for byte ops, one word for push/jump/call.
//   - Flushes and refetches on any non-sequential address (jump, call, ret, cjump taken).

---
 rtl/fetch_buffer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//   Instruction prefetch stage between program memory and the stack CPU core.
//   Streams consecutive 16-bit words ahead of the CPU into a small FIFO, serves
//   CPU word requests with one cycle of latency, and flushes/refetches on any
//   non-sequential address.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | no memory read outstanding (FIFO full, or just reset)
//   S_READ | one read outstanding; mem_rd/mem_addr held until mem_ack
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        synchronous reset, active-high
//   i_cpu_req    CPU requests the word at i_cpu_addr this cycle
//   i_cpu_addr   CPU word address
//   o_cpu_valid  o_cpu_data holds the word for the previous cycle's request
//   o_cpu_data   instruction word
//   o_mem_rd     memory read request, held until i_mem_ack
//   o_mem_addr   memory word address, stable while o_mem_rd=1
//   i_mem_ack    read done; i_mem_data valid this cycle
//   i_mem_data   memory read data
// -----------------------------------------------------------------------------
module fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 15
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cpu_req,
    input  logic [AW-1:0] i_cpu_addr,
    output logic          o_cpu_valid,
    output logic [15:0]   o_cpu_data,
    output logic          o_mem_rd,
    output logic [AW-1:0] o_mem_addr,
    input  logic          i_mem_ack,
    input  logic [15:0]   i_mem_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {S_IDLE = 1'b0, S_READ = 1'b1} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_count, w_count_nxt;
    logic [PW-1:0] r_rd_ptr, w_rd_ptr_nxt, w_rd_ptr_p1, w_wr_ptr;
    logic [AW-1:0] r_head_addr, w_head_nxt, w_head_plus1;
    logic [AW-1:0] r_fetch_addr, w_fetch_base, w_fetch_nxt;
    logic [AW-1:0] r_mem_addr;
    logic          r_stale, w_stale_nxt;
    logic [15:0]   r_fifo [DEPTH];
    logic          r_cpu_valid;
    logic [15:0]   r_cpu_data;
    logic          w_reading, w_ack, w_hit, w_next, w_restart;
    logic          w_push, w_pop, w_issue;

    // Request decode and next-value datapath
    always_comb begin
        w_reading    = (r_state == S_READ);
        w_ack        = w_reading && i_mem_ack;
        w_head_plus1 = r_head_addr + AW'(1);
        w_hit        = i_cpu_req && (i_cpu_addr == r_head_addr);
        w_next       = i_cpu_req && (i_cpu_addr == w_head_plus1);
        // A sequential step past an empty FIFO behaves like a flush to the
        // new head: any in-flight word belongs to the old head and must go.
        w_restart    = i_cpu_req && ((!w_hit && !w_next) || (w_next && r_count == '0));
        w_pop        = w_next && (r_count != '0);
        w_push       = w_ack && !r_stale && !w_restart;
        w_wr_ptr     = r_rd_ptr + r_count[PW-1:0];
        w_rd_ptr_p1  = r_rd_ptr + PW'(1);

        if (w_restart)
            w_count_nxt = '0;
        else
            w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

        w_rd_ptr_nxt = w_pop ? w_rd_ptr_p1 : r_rd_ptr;

        if (w_restart)
            w_head_nxt = i_cpu_addr;
        else if (w_pop)
            w_head_nxt = w_head_plus1;
        else
            w_head_nxt = r_head_addr;

        // Ack in the flush cycle discards the data without marking stale.
        if (w_ack)
            w_stale_nxt = 1'b0;
        else if (w_restart && w_reading)
            w_stale_nxt = 1'b1;
        else
            w_stale_nxt = r_stale;

        w_fetch_base = w_restart ? i_cpu_addr : r_fetch_addr;
        // After an ack nothing is in flight, so space is judged on count alone.
        w_issue      = (!w_reading || w_ack) && (w_count_nxt < DEPTH_C);
        w_fetch_nxt  = w_fetch_base + AW'(w_issue);
    end

    // FSM: state register
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_issue) w_state_nxt = S_READ;
            S_READ:  if (w_ack)   w_state_nxt = w_issue ? S_READ : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_mem_rd    = (r_state == S_READ);
        o_mem_addr  = r_mem_addr;
        o_cpu_valid = r_cpu_valid;
        o_cpu_data  = r_cpu_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_head_addr  <= '0;
            r_fetch_addr <= '0;
            r_mem_addr   <= '0;
            r_stale      <= 1'b0;
            r_cpu_valid  <= 1'b0;
            r_cpu_data   <= '0;
        end else begin
            r_count      <= w_count_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_head_addr  <= w_head_nxt;
            r_fetch_addr <= w_fetch_nxt;
            r_stale      <= w_stale_nxt;
            if (w_issue)
                r_mem_addr <= w_fetch_base;

            // Served from the FIFO as it stood before this edge: no forwarding
            // of a word that is being acked in the same cycle.
            if (w_hit && r_count != '0) begin
                r_cpu_valid <= 1'b1;
                r_cpu_data  <= r_fifo[r_rd_ptr];
            end else if (w_next && r_count > CW'(1)) begin
                r_cpu_valid <= 1'b1;
                r_cpu_data  <= r_fifo[w_rd_ptr_p1];
            end else begin
                r_cpu_valid <= 1'b0;
            end
        end
    end

    // Storage; count/pointers alone decide which entries are live.
    always_ff @(posedge i_clk) begin
        if (w_push)
            r_fifo[w_wr_ptr] <= i_mem_data;
    end

endmodule
